sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider.sv | 74 +++++++
 tb/tb_sequential_divider.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// sequential_divider: unsigned restoring divider, one quotient bit per clock, MSB first
// Ports: clk/rst (sync, active-high); start,a,b request a divide while ready;
// done pulses for one cycle as quo/rem/dbz take the new result and hold it.
module sequential_divider #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic            ready,
  output logic            done,
  output logic [size-1:0] quo,
  output logic [size-1:0] rem,
  output logic            dbz
);
  localparam int CW = $clog2(size + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state_q;
  logic [size-1:0] a_q, b_q;
  logic [size:0]   p_q;
  logic [CW-1:0]   cnt_q;
  logic [size:0]   s_d, p_d;
  logic            ge_d;
  // a_q shifts dividend bits out of its MSB while quotient bits enter at its LSB.
  // p_q[size] is always clear because the remainder stays below the divisor.
  always_comb begin
    s_d  = {p_q[size-1:0], a_q[size-1]};
    ge_d = p_q[size] | (s_d >= {1'b0, b_q});
    p_d  = ge_d ? s_d - {1'b0, b_q} : s_d;
  end
  // Outputs lag the state by one edge, so ready drops the cycle after acceptance
  // and done/results appear the cycle after the FSM reaches DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      dbz     <= 1'b0;
    end else begin
      ready <= state_q == IDLE;
      done  <= state_q == DONE;
      case (state_q)
        IDLE: if (start && ready) begin
          a_q     <= a;
          b_q     <= b;
          p_q     <= '0;
          cnt_q   <= CW'(size);
          state_q <= b == '0 ? DONE : CALC;
        end
        CALC: begin
          p_q     <= p_d;
          a_q     <= {a_q[size-2:0], ge_d};
          cnt_q   <= cnt_q - CW'(1);
          state_q <= cnt_q == CW'(1) ? DONE : CALC;
        end
        DONE: begin
          quo     <= b_q == '0 ? '1 : a_q;
          rem     <= b_q == '0 ? a_q : p_q[size-1:0];
          dbz     <= b_q == '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: scoreboard bench for sequential_divider with directed vectors
module tb_sequential_divider;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       ready, done, dbz;
  logic [7:0] quo, rem;
  typedef struct {logic [7:0] q; logic [7:0] r; logic z; int e;} exp_t;
  exp_t sb[$];
  int   tests = 0;
  int   errs = 0;
  int   cyc = 0;
  int   e0 = 0;
  sequential_divider #(.size(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .quo(quo), .rem(rem), .dbz(dbz)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        errs++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quo", 32'(quo), 32'(e.q));
        chk("rem", 32'(rem), 32'(e.r));
        chk("dbz", 32'(dbz), 32'(e.z));
        chk("done_cycle", cyc, e.e);
        chk("ready_at_done", 32'(ready), 0);
      end
    end
  end
  task automatic go(input logic [7:0] x, input logic [7:0] y, input bit push, input logic [7:0] q, input logic [7:0] r, input bit z);
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("ready_timeout", 32'(ready), 1);
    start = 1'b1;
    a = x;
    b = y;
    e0 = cyc + 1;
    if (push) sb.push_back('{q, r, z, e0 + (y == 0 ? 1 : 9)});
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input bit noise);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (noise) begin
        if (cyc - e0 == 2 || cyc - e0 == 4) begin
          start = 1'b1;
          a = 8'd50;
          b = 8'd5;
        end else begin
          start = 1'b0;
          a = 8'($urandom);
          b = 8'($urandom);
        end
      end
      if (done === 1'b1) seen = 1;
      else if (cyc > e0) chk("ready_busy", 32'(ready), 0);
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_quo", 32'(quo), 0);
    chk("rst_rem", 32'(rem), 0);
    chk("rst_dbz", 32'(dbz), 0);
    go(100, 7, 1, 14, 2, 0);   wait_done(0);
    go(255, 1, 1, 255, 0, 0);  wait_done(0);
    go(3, 10, 1, 0, 3, 0);     wait_done(0);
    go(0, 5, 1, 0, 0, 0);      wait_done(0);
    go(255, 255, 1, 1, 0, 0);  wait_done(0);
    go(5, 0, 1, 255, 5, 1);    wait_done(0);
    go(12, 5, 1, 2, 2, 0);     wait_done(0);
    go(100, 7, 1, 14, 2, 0);   wait_done(1);
    repeat (4) @(negedge clk);
    go(200, 3, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 1);
    chk("abort_done", 32'(done), 0);
    chk("abort_quo", 32'(quo), 0);
    chk("abort_rem", 32'(rem), 0);
    chk("abort_dbz", 32'(dbz), 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
    go(100, 7, 1, 14, 2, 0);   wait_done(0);
    go(9, 2, 1, 4, 1, 0);      wait_done(0);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", tests, errs);
    $finish;
  end
endmodule
